// File: rtl/mha_sched_pkg.sv
// Shared types and defaults for the multi-head attention scheduler.
// Holds the FSM state enum, default geometry and the width helper used
// to size head tags, tile indices and the accumulate counter.
package mha_sched_pkg;

  localparam int NUM_HEADS_DEF      = 4;
  localparam int TILES_PER_HEAD_DEF = 8;
  localparam int ACC_CYCLES_DEF     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_FIN   = 3'd6
  } sched_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TAG_W_DEF  = clog2_min1(NUM_HEADS_DEF);
  localparam int TILE_W_DEF = clog2_min1(TILES_PER_HEAD_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requesting index at or after the
// rotating pointer (with wrap). The pointer moves just past the winner
// only when the grant is actually taken, so an idle arbiter keeps its place.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_accept,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_vld
);

  logic [IDX_W-1:0] r_ptr;

  // Scan offsets from the far end so the smallest offset from r_ptr wins.
  always_comb begin
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(r_ptr) + k) % N]) begin
        o_grant_idx = IDX_W'((int'(r_ptr) + k) % N);
        o_grant_vld = 1'b1;
      end
    end
  end

  // Advance the pointer to winner+1 (mod N) when the grant is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= (int'(o_grant_idx) == N - 1) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mha_head_scheduler.sv
// Multi-head attention scheduler: time-multiplexes NUM_HEADS heads onto one
// shared Qn*KnT systolic + softmax engine, sequencing clear/accumulate/
// out-valid per tile and reporting per-head and global completion.
// Optional build macro MHA_HEAD_MASK_EN adds the head_mask input; masked
// heads are treated as already complete for the whole pass.
module mha_head_scheduler
  import mha_sched_pkg::*;
#(
  parameter  int NUM_HEADS      = NUM_HEADS_DEF,
  parameter  int TILES_PER_HEAD = TILES_PER_HEAD_DEF,
  parameter  int ACC_CYCLES     = ACC_CYCLES_DEF,
  localparam int TAG_W          = clog2_min1(NUM_HEADS),
  localparam int TILE_W         = clog2_min1(TILES_PER_HEAD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_HEADS-1:0] head_ready,
  output logic [NUM_HEADS-1:0] head_release,
  output logic                 eng_rst,
  output logic                 eng_acc_clr,
  output logic                 eng_enable,
  output logic                 eng_out_valid,
  output logic [TAG_W-1:0]     eng_head_sel,
  output logic [TILE_W-1:0]    eng_tile_idx,
  input  logic                 sm_done,
  output logic                 busy,
  output logic [NUM_HEADS-1:0] head_done,
  output logic                 done
`ifdef MHA_HEAD_MASK_EN
  ,
  input  logic [NUM_HEADS-1:0] head_mask
`endif
);

  localparam int CNT_W = clog2_min1(ACC_CYCLES);

  sched_state_t         r_state;
  logic [NUM_HEADS-1:0] r_head_done;
  logic [NUM_HEADS-1:0] r_release;
  logic [TAG_W-1:0]     r_head_sel;
  logic [TILE_W-1:0]    r_tile;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_eng_rst;
  logic                 r_acc_clr;
  logic                 r_enable;
  logic                 r_out_valid;
  logic                 r_busy;
  logic                 r_done;

  logic [NUM_HEADS-1:0] w_init_done;
  logic [NUM_HEADS-1:0] w_req;
  logic [NUM_HEADS-1:0] w_sel_onehot;
  logic [TAG_W-1:0]     w_grant_idx;
  logic                 w_grant_vld;
  logic                 w_accept;
  logic                 w_last_tile;

  // Masked heads start the pass already marked complete so they are never
  // requested, granted or released.
`ifdef MHA_HEAD_MASK_EN
  assign w_init_done = ~head_mask;
`else
  assign w_init_done = '0;
`endif

  // A head competes while its buffer is full and it has not finished yet;
  // head_ready of the owning head is irrelevant once granted.
  assign w_req        = head_ready & ~r_head_done;
  assign w_accept     = (r_state == ST_ARB) && w_grant_vld;
  assign w_sel_onehot = NUM_HEADS'(1) << r_head_sel;
  assign w_last_tile  = (r_tile == TILE_W'(TILES_PER_HEAD - 1));

  rr_arbiter #(
    .N     (NUM_HEADS),
    .IDX_W (TAG_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (w_req),
    .i_accept    (w_accept),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_grant_vld)
  );

  // Scheduler FSM with registered engine controls, pulses and bitmaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_head_done <= '0;
      r_release   <= '0;
      r_head_sel  <= '0;
      r_tile      <= '0;
      r_cnt       <= '0;
      r_eng_rst   <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_enable    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_release   <= '0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_ARB;
            r_busy      <= 1'b1;
            r_head_done <= w_init_done;
          end
        end
        ST_ARB: begin
          if (w_grant_vld) begin
            r_head_sel <= w_grant_idx;
            r_tile     <= '0;
            r_eng_rst  <= 1'b1;
            r_acc_clr  <= 1'b1;
            r_state    <= ST_CLEAR;
          end else if (&r_head_done) begin
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end
        end
        ST_CLEAR: begin
          r_eng_rst <= 1'b0;
          r_acc_clr <= 1'b0;
          r_enable  <= 1'b1;
          r_cnt     <= CNT_W'(ACC_CYCLES - 1);
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          if (r_cnt == '0) begin
            r_enable    <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_WAIT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (sm_done) begin
            r_state <= ST_NEXT;
            if (w_last_tile) begin
              r_head_done <= r_head_done | w_sel_onehot;
              r_release   <= w_sel_onehot;
            end
          end
        end
        ST_NEXT: begin
          if (!w_last_tile) begin
            r_tile    <= r_tile + 1'b1;
            r_eng_rst <= 1'b1;
            r_acc_clr <= 1'b1;
            r_state   <= ST_CLEAR;
          end else begin
            r_state <= ST_ARB;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign head_release  = r_release;
  assign eng_rst       = r_eng_rst;
  assign eng_acc_clr   = r_acc_clr;
  assign eng_enable    = r_enable;
  assign eng_out_valid = r_out_valid;
  assign eng_head_sel  = r_head_sel;
  assign eng_tile_idx  = r_tile;
  assign busy          = r_busy;
  assign head_done     = r_head_done;
  assign done          = r_done;

endmodule

// File: tb/tb_mha_head_scheduler.sv
// Self-checking bench for mha_head_scheduler (4 heads, 2 tiles, 4 acc cycles).
// Grant order is predicted from the round-robin rule over the set of ready
// heads; per-head reset pulses, enable cycles and out-valid pulses are
// predicted from the tile/accumulate geometry.
module tb_mha_head_scheduler;

  localparam int NH = 4;
  localparam int TL = 2;
  localparam int AC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sm_done;
  logic [3:0] head_ready;
  logic [3:0] head_release;
  logic [3:0] head_done;
  logic       eng_rst, eng_acc_clr, eng_enable, eng_out_valid;
  logic [1:0] eng_head_sel;
  logic [0:0] eng_tile_idx;
  logic       busy, done;
`ifdef MHA_HEAD_MASK_EN
  logic [3:0] head_mask;
`endif

  always #5 clk = ~clk;

  mha_head_scheduler #(
    .NUM_HEADS      (NH),
    .TILES_PER_HEAD (TL),
    .ACC_CYCLES     (AC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .head_ready    (head_ready),
    .head_release  (head_release),
    .eng_rst       (eng_rst),
    .eng_acc_clr   (eng_acc_clr),
    .eng_enable    (eng_enable),
    .eng_out_valid (eng_out_valid),
    .eng_head_sel  (eng_head_sel),
    .eng_tile_idx  (eng_tile_idx),
    .sm_done       (sm_done),
    .busy          (busy),
    .head_done     (head_done),
    .done          (done)
`ifdef MHA_HEAD_MASK_EN
    ,
    .head_mask     (head_mask)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  int g_order[$];
  int rst_cnt[NH];
  int en_cnt, ov_cnt, done_cnt, done_cyc, first_rst, first_en, first_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {15'd0, head_release, eng_rst, eng_acc_clr, eng_enable, eng_out_valid,
            eng_head_sel, eng_tile_idx, busy, head_done, done};
  endfunction

  // Runs one pass from a negedge; returns at a negedge. Grants are predicted
  // by the round-robin rule: ready heads first in circular order from the
  // pointer, then (after they release and all heads turn ready) the rest in
  // circular order from just past the last granted head.
  task automatic run_pass(input logic [3:0] ready0, input logic [3:0] mask,
                          input int dmin, input int dmax, input bit noise,
                          input bit start_in_run, input bit abort_h1);
    int exp_order[$];
    int cyc, sm_cnt, p, nact;
    logic [3:0] released, grp;
    bit injected;
    g_order.delete();
    for (int h = 0; h < NH; h++) rst_cnt[h] = 0;
    en_cnt = 0; ov_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_rst = -1; first_en = -1; first_ov = -1;

    grp = ready0 & mask;
    p = m_ptr;
    for (int i = 0; i < NH; i++) if (grp[(p + i) % NH]) exp_order.push_back((p + i) % NH);
    if (exp_order.size() > 0) p = (exp_order[exp_order.size() - 1] + 1) % NH;
    for (int i = 0; i < NH; i++)
      if (mask[(p + i) % NH] && !grp[(p + i) % NH]) exp_order.push_back((p + i) % NH);
    nact = $countones(mask);

    head_ready = ready0;
    start = 1'b1;
`ifdef MHA_HEAD_MASK_EN
    head_mask = mask;
`endif
    @(negedge clk);
    start = 1'b0;
    cyc = 1; sm_cnt = -1; released = '0; injected = 1'b0;
    chk("busy_after_start", busy, 1);

    while (done_cnt == 0 && cyc < 2000) begin
      if (abort_h1 && eng_enable && eng_head_sel == 2'd1) begin
        rst = 1'b1; sm_done = 1'b0;
        @(negedge clk);
        chk("abort_outputs_zero", all_outs(), 0);
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("abort_no_done", {done, busy, eng_rst, eng_enable}, 0);
        end
        return;
      end
      if (eng_rst) begin
        if (eng_tile_idx == 1'b0) g_order.push_back(int'(eng_head_sel));
        rst_cnt[eng_head_sel]++;
        if (first_rst < 0) first_rst = cyc;
      end
      if (eng_enable) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
      end
      if (eng_out_valid) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = cyc;
        sm_cnt = $urandom_range(dmax, dmin);
      end else if (sm_cnt > 0) begin
        chk("wait_quiet", {eng_rst, eng_enable, eng_out_valid}, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (|head_release) begin
        released |= head_release;
        if ((released & grp) == grp) head_ready = 4'hF;
      end
      if (start_in_run && eng_enable && !injected) begin
        start = 1'b1; injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      sm_done = 1'b0;
      if (sm_cnt == 0) begin
        sm_done = 1'b1; sm_cnt = -1;
      end else if (sm_cnt > 0) begin
        sm_cnt--;
      end else if (noise) begin
        sm_done = 1'($urandom_range(1, 0));
      end
      @(negedge clk);
      cyc++;
    end
    sm_done = 1'b0;
    start = 1'b0;

    chk("done_seen_once", done_cnt, 1);
    chk("after_fin_idle", {done, busy}, 0);
    chk("grant_count", g_order.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < g_order.size(); i++)
      chk($sformatf("grant_%0d", i), g_order[i], exp_order[i]);
    for (int h = 0; h < NH; h++)
      chk($sformatf("rst_pulses_h%0d", h), rst_cnt[h], mask[h] ? TL : 0);
    chk("enable_cycles", en_cnt, nact * TL * AC);
    chk("out_valid_pulses", ov_cnt, nact * TL);
    chk("head_done_final", head_done, 4'hF);
    if (exp_order.size() > 0) m_ptr = (exp_order[exp_order.size() - 1] + 1) % NH;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sm_done = 1'b0; head_ready = '0;
`ifdef MHA_HEAD_MASK_EN
    head_mask = 4'hF;
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 0);

    // All heads ready from the start: latency and 0,1,2,3 order.
    run_pass(4'hF, 4'hF, 1, 1, 1'b0, 1'b0, 1'b0);
    chk("lat_eng_rst", first_rst, 2);
    chk("lat_eng_enable", first_en, 3);
    chk("lat_out_valid", first_ov, 3 + AC);

    // Only head 2 ready at first: 2 then wrap 3,0,1.
    run_pass(4'b0100, 4'hF, 1, 1, 1'b0, 1'b0, 1'b0);

    // Softmax slow to answer: engine idle, out_valid pulses once per tile.
    run_pass(4'hF, 4'hF, 20, 20, 1'b0, 1'b0, 1'b0);

    // Start pulse while busy has no effect.
    run_pass(4'hF, 4'hF, 0, 2, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of head 1, then a complete fresh pass.
    run_pass(4'hF, 4'hF, 0, 2, 1'b0, 1'b0, 1'b1);
    run_pass(4'hF, 4'hF, 0, 2, 1'b0, 1'b0, 1'b0);

    // Randomized ready sets, softmax delays and stray sm_done outside WAIT.
    for (int t = 0; t < 6; t++)
      run_pass(4'($urandom_range(15, 1)), 4'hF, 0, 4, 1'b1, 1'b0, 1'b0);

`ifdef MHA_HEAD_MASK_EN
    run_pass(4'hF, 4'b1010, 0, 2, 1'b0, 1'b0, 1'b0);
    run_pass(4'hF, 4'b0000, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("mask0_done_cycle", done_cyc, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
